// File: rtl/out_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : out_port_pkg
//  Description : Shared word type, word width and halt-tracking state type
//                for the core output-port FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package out_port_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

endpackage : out_port_pkg
`default_nettype wire

// File: rtl/out_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : out_fifo_ram
//  Description : DEPTH x word_t storage for the output-port FIFO.
//                Synchronous write, asynchronous (combinational) read, no
//                reset -- the pointers in the parent decide what is valid.
//  Ports       : clk       - system clock, rising edge
//                i_wr_en   - write strobe
//                i_wr_addr - write address
//                i_wr_dat  - write data
//                i_rd_addr - read address
//                o_rd_dat  - read data (combinational from i_rd_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module out_fifo_ram
    import out_port_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  word_t             i_wr_dat,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output word_t             o_rd_dat
);

    word_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule : out_fifo_ram
`default_nettype wire

// File: rtl/out_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : out_port_fifo
//  Description : Buffers words strobed out of the fst core (out_en/out_dat)
//                and drains them to a slower sink over valid/ready. The head
//                entry falls through combinationally from storage. Also
//                tracks core halt so the top level can tell when all program
//                output has been delivered (drained).
//  Config      : OUT_PORT_FIFO_CNT_EN - when defined, adds total_cnt, a
//                16-bit wrapping count of accepted pushes.
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous active-low reset
//                out_en     - core output strobe
//                out_dat    - core output word
//                is_halt    - core halt flag
//                dout_valid - head entry available
//                dout_ready - sink accepts head entry
//                dout_dat   - head entry, 0 when empty
//                count      - current occupancy (0..DEPTH)
//                overflow   - sticky, a strobe was dropped while full
//                total_cnt  - accepted-push counter (OUT_PORT_FIFO_CNT_EN)
//                drained    - halt seen and FIFO empty
//  Revision    : 1.0 - initial release
// ============================================================================
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     out_en,
    input  logic [WORD_W-1:0]        out_dat,
    input  logic                     is_halt,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [WORD_W-1:0]        dout_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
`ifdef OUT_PORT_FIFO_CNT_EN
    output logic [15:0]              total_cnt,
`endif
    output logic                     drained
);

    localparam int                  c_addr_w    = $clog2(DEPTH);
    localparam int                  c_cnt_w     = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth_cnt = c_cnt_w'(DEPTH);

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overflow;
    halt_state_t         r_state;
    halt_state_t         w_state_nxt;

    logic  w_empty;
    logic  w_full;
    logic  w_push;
    logic  w_pop;
    word_t w_rd_dat;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth_cnt);

    // Pop only when something is there; a push into a full FIFO is allowed
    // when the head leaves in the same cycle, which keeps sustained
    // one-in/one-out throughput at full occupancy.
    assign w_pop  = !w_empty && dout_ready;
    assign w_push = out_en && (!w_full || w_pop);

    out_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (out_dat),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_dat)
    );

    // Pointers and occupancy. DEPTH is a power of two, so the natural
    // binary wrap of the pointers is the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag: only a strobe that could not be accepted sets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (out_en && !w_push) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef OUT_PORT_FIFO_CNT_EN
    logic [15:0] r_total_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total_cnt <= '0;
        end else if (w_push) begin
            r_total_cnt <= r_total_cnt + 16'd1;
        end
    end

    assign total_cnt = r_total_cnt;
`endif

    // Halt tracking: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt tracking: next state (HALTED is only left by reset)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (is_halt) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    // Halt tracking: output
    always_comb begin
        drained = (r_state == HALTED) && w_empty;
    end

    // All outputs derive from registered state only; dout_ready never
    // reaches them combinationally.
    assign dout_valid = !w_empty;
    assign dout_dat   = w_empty ? '0 : w_rd_dat;
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule : out_port_fifo
`default_nettype wire

// File: tb/tb_out_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_port_fifo
//  Description : Self-checking bench for out_port_fifo (DEPTH=8). A queue
//                model tracks expected contents/flags; a compare process
//                checks every output on each falling clock edge, and
//                directed scenarios add literal expectations.
//  Config      : OUT_PORT_FIFO_CNT_EN - also checks total_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_fifo;

    localparam int DEPTH = 8;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        out_en     = 1'b0;
    logic [15:0] out_dat    = '0;
    logic        is_halt    = 1'b0;
    logic        dout_ready = 1'b0;
    logic        dout_valid;
    logic [15:0] dout_dat;
    logic [3:0]  count;
    logic        overflow;
    logic        drained;
`ifdef OUT_PORT_FIFO_CNT_EN
    logic [15:0] total_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    out_port_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .out_en     (out_en),
        .out_dat    (out_dat),
        .is_halt    (is_halt),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_dat   (dout_dat),
        .count      (count),
        .overflow   (overflow),
`ifdef OUT_PORT_FIFO_CNT_EN
        .total_cnt  (total_cnt),
`endif
        .drained    (drained)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_q[$];
    logic        m_ovf    = 1'b0;
    logic        m_halted = 1'b0;
    logic [15:0] m_total  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ovf    <= 1'b0;
            m_halted <= 1'b0;
            m_total  <= '0;
        end else begin
            if (m_q.size() > 0 && dout_ready) void'(m_q.pop_front());
            if (out_en) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(out_dat);
                    m_total <= m_total + 16'd1;
                end else begin
                    m_ovf <= 1'b1;
                end
            end
            if (is_halt) m_halted <= 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmp_valid", int'(dout_valid), int'(m_q.size() > 0));
        chk("cmp_dat",   int'(dout_dat),   (m_q.size() > 0) ? int'(m_q[0]) : 0);
        chk("cmp_count", int'(count),      m_q.size());
        chk("cmp_ovf",   int'(overflow),   int'(m_ovf));
        chk("cmp_drained", int'(drained),  int'(m_halted && m_q.size() == 0));
`ifdef OUT_PORT_FIFO_CNT_EN
        chk("cmp_total", int'(total_cnt),  int'(m_total));
`endif
    end

    // Words the sink actually took, recorded from DUT outputs.
    logic [15:0] got[$];
    always @(negedge clk) begin
        if (reset && dout_valid && dout_ready) got.push_back(dout_dat);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic en, input logic [15:0] d,
                        input logic rdy, input logic h);
        out_en     = en;
        out_dat    = d;
        dout_ready = rdy;
        is_halt    = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_en = 0; out_dat = '0; dout_ready = 0; is_halt = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string name, input logic [15:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, int'(got[i]), int'(exp[i]));
    endtask

    logic [15:0] exp_q[$];

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_dat",   int'(dout_dat), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_drained", int'(drained), 0);
        do_reset();

        // ---- basic push then drain ----
        for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("t1_count", int'(count), 3);
        chk("t1_head",  int'(dout_dat), 16'h0001);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("t1_valid_end", int'(dout_valid), 0);
        chk("t1_dat_end",   int'(dout_dat), 0);
        exp_q = '{16'h0001, 16'h0002, 16'h0003};
        chk_got("t1_order", exp_q);

        // ---- overflow ----
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
        chk("t2_count", int'(count), 8);
        chk("t2_ovf",   int'(overflow), 1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0010 + 16'(i));
        chk_got("t2_order", exp_q);
        chk("t2_ovf_sticky", int'(overflow), 1);

        // ---- full with simultaneous push and pop ----
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("t3_count", int'(count), 8);
        chk("t3_ovf",   int'(overflow), 0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0020 + 16'(i));
        exp_q.push_back(16'hBEEF);
        chk_got("t3_order", exp_q);

        // ---- 20 words, ready toggling, pointer wrap ----
        do_reset();
        begin
            int pushed = 0;
            for (int k = 0; k < 40; k++) begin
                logic en;
                en = (pushed < 20) && (k < 14 || (k % 2) == 0);
                step(en, 16'h0100 + 16'(pushed), k[0], 1'b0);
                if (en) pushed++;
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(16'h0100 + 16'(i));
        chk_got("t4_order", exp_q);
        chk("t4_ovf", int'(overflow), 0);

        // ---- halt tracking ----
        do_reset();
        step(1'b1, 16'h0A01, 1'b0, 1'b0);
        step(1'b1, 16'h0A02, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t5_drained_full", int'(drained), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_drained_one", int'(drained), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t5_drained_empty", int'(drained), 1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t5_drained_held", int'(drained), 1);
        step(1'b1, 16'h0A03, 1'b0, 1'b0);
        chk("t5_push_after_halt", int'(count), 1);
        chk("t5_drained_refill", int'(drained), 0);

        // ---- asynchronous reset mid-stream ----
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
        out_en = 1'b0;
`ifdef OUT_PORT_FIFO_CNT_EN
        chk("t6_total_pre", int'(total_cnt), 3);
`endif
        #1 reset = 1'b0;
        #1;
        chk("t6_valid", int'(dout_valid), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_ovf",   int'(overflow), 0);
        chk("t6_dat",   int'(dout_dat), 0);
`ifdef OUT_PORT_FIFO_CNT_EN
        chk("t6_total_post", int'(total_cnt), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 16'h0D00, 1'b0, 1'b0);
        chk("t6_first_push", int'(count), 1);
        chk("t6_first_head", int'(dout_dat), 16'h0D00);

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_out_port_fifo
`default_nettype wire

// File: doc/out_port_fifo.md
# out_port_fifo

Buffers words the `fst` core emits on its output port (`out_en`/`out_dat`) and drains them to a downstream consumer (display/serial driver) over a valid/ready handshake. Sits directly downstream of the core, decoupling single-cycle output strobes from a slower sink. Also tracks core halt so the top level knows when all program output has been delivered.

## Interface
- `DEPTH`, 8, number of 16-bit entries; power of two, ≥2
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset; state clears while `reset`=0
- `out_en`  in  1  core output strobe; one word per cycle when high
- `out_dat`  in  16  core output word, sampled when `out_en`=1
- `is_halt`  in  1  core halt flag
- `dout_valid`  out  1  head entry available
- `dout_ready`  in  1  sink accepts head entry this cycle
- `dout_dat`  out  16  head entry; 0 when empty
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a strobe was dropped
- `drained`  out  1  halt seen and FIFO empty

## Operation
- Push: `out_en`=1 and (not full, or pop in same cycle) → `out_dat` written at `wr_ptr`, `wr_ptr` advances.
- Pop: `dout_valid`=1 and `dout_ready`=1 → `rd_ptr` advances.
- Full, `out_en`=1, no pop → word dropped, `overflow` set; it stays set until reset.
- Full, push and pop together → both occur; `count` stays at DEPTH; no overflow.
- Empty, push and `dout_ready`=1 together → no bypass; word is pushed, `dout_valid` rises next cycle.
- Pointers wrap modulo DEPTH. `count` = pushes − pops and is never outside 0..DEPTH.
- Halt tracking uses a two-state FSM:
  - RUN → HALTED on the first `is_halt`=1 sample.
  - HALTED is left only by reset.
- `drained` = (state==HALTED) && (count==0), combinational.
- Strobes after halt are still accepted.
- Reset values: `count`=0, pointers 0, `dout_valid`=0, `dout_dat`=0, `overflow`=0, state RUN, `drained`=0.

## Timing
- Write latency: a word pushed at edge N gives `dout_valid`=1 and `dout_dat`=word after edge N.
- First-word fall-through: `dout_dat` is muxed from storage at `rd_ptr`, with no extra register stage.
- `dout_valid`, `dout_dat`, `count` and `drained` depend only on registered state; none is combinational from `dout_ready`.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation immediately empties the FIFO (asynchronous). Storage contents need not clear; outputs must be reset values while `reset`=0.
- First push is possible at the first rising edge after `reset` returns to 1.

## Configuration
- `OUT_PORT_FIFO_CNT_EN` defined:
  - Adds output port `total_cnt` [15:0].
  - Counts accepted pushes and wraps 0xFFFF→0.
  - Reset value 0.
  - Dropped strobes are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `out_port_pkg` holds:
  - `localparam WORD_W = 16`
  - `typedef logic [WORD_W-1:0] word_t`
  - `typedef enum logic {RUN, HALTED} halt_state_t`
- One sub-module, `out_fifo_ram`:
  - DEPTH×`word_t` storage.
  - Synchronous write, asynchronous read.
  - No reset.
- Pointer, count, flag and FSM logic live in `out_port_fifo`.

## Test plan
- Reset, then push 0x0001..0x0003 on consecutive cycles with `dout_ready`=0 → `count`=3, `dout_dat`=0x0001. Then raise `dout_ready` → reads 1,2,3 on consecutive cycles, then `dout_valid`=0, `dout_dat`=0.
- With DEPTH=8 and `dout_ready`=0, push 9 words 0x0010..0x0018 → `count`=8, `overflow`=1, and draining yields 0x0010..0x0017 only.
- Full FIFO, push 0xBEEF with `dout_ready`=1 in the same cycle → `count` stays 8, `overflow`=0, 0xBEEF is drained last.
- Fill and drain 20 words through DEPTH=8 with `dout_ready` toggling each cycle (pointer wrap) → output order equals input order, no loss.
- Push 2 words, pulse `is_halt`=1 for one cycle, then drain → `drained`=0 until the second pop, then 1 and held.
- Push 3 words, pull `reset` low mid-stream → `dout_valid`, `count` and `overflow` are 0 immediately. With `OUT_PORT_FIFO_CNT_EN`, `total_cnt` reads 3 before reset and 0 after.
